// File: rtl/ball_engine.sv
// Pong ball engine: registered ball datapath, serve/run/game-over control,
// step-rate divider and per-player saturating score counters.
module ball_engine #(
  parameter int unsigned X_W       = 3,
  parameter int unsigned Y_W       = 3,
  parameter int unsigned PADDLE_W  = 2,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned SCORE_W   = 2,
  parameter int unsigned WIN_SCORE = 3,
  parameter int unsigned SERVE_X   = 3,
  parameter int unsigned SERVE_Y   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     paddle_top,
  input  logic [X_W-1:0]     paddle_bot,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               running,
  output logic               miss_top,
  output logic               miss_bot,
  output logic [SCORE_W-1:0] score_top,
  output logic [SCORE_W-1:0] score_bot,
  output logic               endgame
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [X_W-1:0]     XMAX   = '1;
  localparam logic [Y_W-1:0]     YMAX   = '1;
  localparam logic [Y_W-1:0]     Y_ONE  = Y_W'(1);
  localparam logic [Y_W-1:0]     Y_PEN  = YMAX - Y_W'(1);
  localparam logic [X_W-1:0]     SX     = X_W'(SERVE_X);
  localparam logic [Y_W-1:0]     SY     = Y_W'(SERVE_Y);
  localparam logic [X_W:0]       P_SPAN = (X_W+1)'(PADDLE_W - 1);
  localparam logic [SCORE_W-1:0] S_MAX  = '1;
  localparam logic [SCORE_W-1:0] S_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [TW-1:0]      T_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     bx_q, bx_d;
  logic [Y_W-1:0]     by_q, by_d;
  logic               dx_q, dx_d;
  logic               dy_q, dy_d;
  logic               serve_q, serve_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [SCORE_W-1:0] st_q, st_d;
  logic [SCORE_W-1:0] sb_q, sb_d;
  logic               mt_q, mt_d;
  logic               mb_q, mb_d;
  logic               run_q, run_d;
  logic               over_q, over_d;

  logic [X_W:0]       bx_ext;
  logic [X_W:0]       pt_ext;
  logic [X_W:0]       pb_ext;
  logic               hit_top, hit_bot;
  logic               step_dx, step_dy;
  logic [X_W-1:0]     step_x;
  logic [Y_W-1:0]     step_y;
  logic [SCORE_W-1:0] st_inc, sb_inc;

  // Next ball position/direction for one step, from pre-move ball and paddles.
  // Paddle span is compared one bit wider so a paddle near XMAX never wraps.
  always_comb begin
    bx_ext  = {1'b0, bx_q};
    pt_ext  = {1'b0, paddle_top};
    pb_ext  = {1'b0, paddle_bot};
    hit_top = (pt_ext <= bx_ext) && (bx_ext <= pt_ext + P_SPAN);
    hit_bot = (pb_ext <= bx_ext) && (bx_ext <= pb_ext + P_SPAN);

    step_dx = dx_q;
    if (bx_q == '0) begin
      step_dx = 1'b1;
    end else if (bx_q == XMAX) begin
      step_dx = 1'b0;
    end

    step_dy = dy_q;
    if ((by_q == Y_ONE) && !dy_q && hit_top) begin
      step_dy = 1'b1;
    end else if ((by_q == Y_PEN) && dy_q && hit_bot) begin
      step_dy = 1'b0;
    end

    step_x = step_dx ? bx_q + 1'b1 : bx_q - 1'b1;
    step_y = step_dy ? by_q + 1'b1 : by_q - 1'b1;

    st_inc = (st_q == S_MAX) ? S_MAX : st_q + 1'b1;
    sb_inc = (sb_q == S_MAX) ? S_MAX : sb_q + 1'b1;
  end

  // Control: serve hold, step divider, miss scoring and game-over handling.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    serve_d = serve_q;
    tick_d  = tick_q;
    st_d    = st_q;
    sb_d    = sb_q;
    mt_d    = 1'b0;
    mb_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        bx_d = SX;
        by_d = SY;
        dx_d = 1'b1;
        dy_d = serve_q;
        if (start) begin
          state_d = RUN;
          tick_d  = '0;
        end
      end
      RUN: begin
        if (tick_q == T_LAST) begin
          tick_d = '0;
          bx_d   = step_x;
          by_d   = step_y;
          dx_d   = step_dx;
          dy_d   = step_dy;
          if (step_y == '0) begin
            mt_d    = 1'b1;
            sb_d    = sb_inc;
            serve_d = 1'b0;
            state_d = (sb_inc == S_WIN) ? OVER : IDLE;
          end else if (step_y == YMAX) begin
            mb_d    = 1'b1;
            st_d    = st_inc;
            serve_d = 1'b1;
            state_d = (st_inc == S_WIN) ? OVER : IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          st_d    = '0;
          sb_d    = '0;
          serve_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d  = (state_d == RUN);
    over_d = (state_d == OVER);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bx_q    <= SX;
      by_q    <= SY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      serve_q <= 1'b1;
      tick_q  <= '0;
      st_q    <= '0;
      sb_q    <= '0;
      mt_q    <= 1'b0;
      mb_q    <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      serve_q <= serve_d;
      tick_q  <= tick_d;
      st_q    <= st_d;
      sb_q    <= sb_d;
      mt_q    <= mt_d;
      mb_q    <= mb_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign dir_x     = dx_q;
  assign dir_y     = dy_q;
  assign running   = run_q;
  assign miss_top  = mt_q;
  assign miss_bot  = mb_q;
  assign score_top = st_q;
  assign score_bot = sb_q;
  assign endgame   = over_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine against a game-level reference model.
module tb_ball_engine;

  localparam int X_W       = 3;
  localparam int Y_W       = 3;
  localparam int PADDLE_W  = 2;
  localparam int TICK_DIV  = 4;
  localparam int SCORE_W   = 2;
  localparam int WIN_SCORE = 3;
  localparam int SERVE_X   = 3;
  localparam int SERVE_Y   = 3;
  localparam int XMAX      = (1 << X_W) - 1;
  localparam int YMAX      = (1 << Y_W) - 1;
  localparam int SMAX      = (1 << SCORE_W) - 1;
  localparam int NCYC      = 8000;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [X_W-1:0]     paddle_top;
  logic [X_W-1:0]     paddle_bot;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic               dir_x, dir_y, running, miss_top, miss_bot, endgame;
  logic [SCORE_W-1:0] score_top, score_bot;

  always #5 clk = ~clk;

  ball_engine #(
    .X_W(X_W), .Y_W(Y_W), .PADDLE_W(PADDLE_W), .TICK_DIV(TICK_DIV),
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .SERVE_X(SERVE_X), .SERVE_Y(SERVE_Y)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .paddle_top(paddle_top), .paddle_bot(paddle_bot),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .running(running), .miss_top(miss_top), .miss_bot(miss_bot),
    .score_top(score_top), .score_bot(score_bot), .endgame(endgame)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference game state: "idle", "run" or "over".
  string m_mode;
  int m_x, m_y, m_dx, m_dy, m_serve, m_cnt, m_st, m_sb, m_mt, m_mb;

  task automatic model_reset();
    m_mode = "idle";
    m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = 1; m_serve = 1;
    m_cnt = 0; m_st = 0; m_sb = 0; m_mt = 0; m_mb = 0;
  endtask

  task automatic model_move(input int pt, input int pb);
    bit ht, hb;
    if (m_x == 0) m_dx = 1;
    else if (m_x == XMAX) m_dx = 0;
    ht = (m_x >= pt) && (m_x <= pt + PADDLE_W - 1);
    hb = (m_x >= pb) && (m_x <= pb + PADDLE_W - 1);
    if (m_y == 1 && m_dy == 0 && ht) m_dy = 1;
    else if (m_y == YMAX - 1 && m_dy == 1 && hb) m_dy = 0;
    m_x += m_dx ? 1 : -1;
    m_y += m_dy ? 1 : -1;
    if (m_y == 0) begin
      m_mt = 1;
      if (m_sb < SMAX) m_sb++;
      m_serve = 0;
      m_mode = (m_sb == WIN_SCORE) ? "over" : "idle";
    end else if (m_y == YMAX) begin
      m_mb = 1;
      if (m_st < SMAX) m_st++;
      m_serve = 1;
      m_mode = (m_st == WIN_SCORE) ? "over" : "idle";
    end
  endtask

  // One clock edge of the game as seen from outside.
  task automatic model_clock(input bit rst, input bit st, input int pt, input int pb);
    if (rst) begin
      model_reset();
    end else begin
      m_mt = 0; m_mb = 0;
      if (m_mode == "idle") begin
        m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = m_serve;
        if (st) begin m_mode = "run"; m_cnt = 0; end
      end else if (m_mode == "run") begin
        m_cnt++;
        if (m_cnt == TICK_DIV) begin
          m_cnt = 0;
          model_move(pt, pb);
        end
      end else begin
        if (st) begin m_st = 0; m_sb = 0; m_serve = 1; m_mode = "idle"; end
      end
    end
  endtask

  task automatic compare_all();
    check("ball_x", int'(ball_x), m_x);
    check("ball_y", int'(ball_y), m_y);
    check("dir_x", int'(dir_x), m_dx);
    check("dir_y", int'(dir_y), m_dy);
    check("running", int'(running), (m_mode == "run") ? 1 : 0);
    check("endgame", int'(endgame), (m_mode == "over") ? 1 : 0);
    check("miss_top", int'(miss_top), m_mt);
    check("miss_bot", int'(miss_bot), m_mb);
    check("score_top", int'(score_top), m_st);
    check("score_bot", int'(score_bot), m_sb);
  endtask

  function automatic int track(input int x);
    int v;
    v = x - int'($urandom_range(0, PADDLE_W - 1));
    if (v < 0) v = 0;
    return v;
  endfunction

  initial begin
    int mode;
    reset = 1'b1; start = 1'b0; paddle_top = '0; paddle_bot = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      model_clock(1'b1, 1'b0, 0, 0);
      #1 compare_all();
    end
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      mode = (cyc / 500) % 4;
      reset = ($urandom_range(0, 299) == 0);
      case (mode)
        0: begin
          // Mostly-good tracking paddles: long rallies, rare start pulses.
          start = ($urandom_range(0, 5) == 0);
          paddle_top = X_W'(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, XMAX)) : track(m_x));
          paddle_bot = X_W'(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, XMAX)) : track(m_x));
        end
        1: begin
          // Paddles jump every cycle; only step-cycle values should matter.
          start = ($urandom_range(0, 3) == 0);
          paddle_top = X_W'($urandom_range(0, XMAX));
          paddle_bot = X_W'($urandom_range(0, XMAX));
        end
        2: begin
          // Start held high through whole games.
          start = 1'b1;
          paddle_top = X_W'(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, XMAX)) : track(m_x));
          paddle_bot = X_W'($urandom_range(0, XMAX));
        end
        default: begin
          // Paddles parked at the right edge alternating with tracking.
          start = ($urandom_range(0, 7) == 0);
          paddle_top = X_W'(($urandom_range(0, 1) == 0) ? XMAX : track(m_x));
          paddle_bot = X_W'(($urandom_range(0, 1) == 0) ? XMAX - 1 : track(m_x));
        end
      endcase
      @(posedge clk);
      model_clock(reset, start, int'(paddle_top), int'(paddle_bot));
      #1 compare_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
